accu_stim_tx: RTL and testbench



---
 rtl/accu_pkg.sv | 22 ++
 rtl/accu_tx_timer.sv | 28 ++
 rtl/accu_stim_tx.sv | 196 +++++++++++++++++++
 tb/tb_accu_stim_tx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/accu_pkg.sv
// Shared definitions for the accumulator stimulus transmitter and accu_top:
// FSM state codes (also used to decode state_display) and default sizing.
package accu_pkg;

  localparam int ACCU_STATE_W     = 3;
  localparam int ACCU_PATTERN_W   = 16;
  localparam int ACCU_GAP_CYCLES  = 8;
  localparam int ACCU_HOLD_CYCLES = 8;

  typedef enum logic [ACCU_STATE_W-1:0] {
    ACCU_IDLE   = 3'd0,
    ACCU_SETUP  = 3'd1,
    ACCU_STROBE = 3'd2,
    ACCU_SAMPLE = 3'd3,
    ACCU_DONE   = 3'd4
  } accu_state_e;

  function automatic int accu_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/accu_tx_timer.sv
// Loadable down-counter shared by the GAP and HOLD phases. zero is high once
// the count has run out; a load of N gives N+1 cycles until the zero cycle.
module accu_tx_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/accu_stim_tx.sv
// Serial stimulus transmitter driving the accumulator next/in interface.
// Latches a pattern, presents one bit per period on in_bit, strobes next
// once per bit and samples resp into resp_word after each strobe.
//
// Optional build macro ACCU_TX_CHECK_EN adds a latched compare word and a
// mismatch flag evaluated on entry to DONE. The compare port is named
// 'expected' because 'expect' is a reserved word in SystemVerilog.
//
// state  | meaning
// IDLE   | waiting for load/start
// SETUP  | in_bit driven, next low, GAP_CYCLES cycles
// STROBE | next high, in_bit held, HOLD_CYCLES cycles
// SAMPLE | next low, resp captured into resp_word[idx]
// DONE   | one-cycle done pulse, back to IDLE
module accu_stim_tx
  import accu_pkg::*;
#(
  parameter int PATTERN_W   = ACCU_PATTERN_W,
  parameter int GAP_CYCLES  = ACCU_GAP_CYCLES,
  parameter int HOLD_CYCLES = ACCU_HOLD_CYCLES,
  parameter int LEN_W       = $clog2(PATTERN_W + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [PATTERN_W-1:0]    pattern,
  input  logic [LEN_W-1:0]        len,
  input  logic                    start,
  input  logic                    resp,
`ifdef ACCU_TX_CHECK_EN
  input  logic [PATTERN_W-1:0]    expected,
  output logic                    mismatch,
`endif
  output logic                    in_bit,
  output logic                    next,
  output logic                    busy,
  output logic                    done,
  output logic [PATTERN_W-1:0]    resp_word,
  output logic [ACCU_STATE_W-1:0] state_display
);

  localparam int CNT_W = $clog2(accu_max(GAP_CYCLES, HOLD_CYCLES) + 1);
  localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PATTERN_W);

  accu_state_e          state_q, state_n;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [PATTERN_W-1:0] resp_word_d;
  logic                 in_bit_d;
  logic [LEN_W-1:0]     len_clamped;
  logic                 last_bit;
  logic                 tmr_load;
  logic [CNT_W-1:0]     tmr_val;
  logic                 tmr_zero;

  assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
  assign last_bit    = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

  // Every state change reloads the timer with the length of the new phase.
  assign tmr_load = (state_n != state_q);
  assign tmr_val  = (state_n == ACCU_STROBE) ? HOLD_LD : GAP_LD;

  accu_tx_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state and next-datapath decode; a same-cycle load feeds start directly.
  always_comb begin
    state_n     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    idx_d       = idx_q;
    resp_word_d = resp_word;
    in_bit_d    = in_bit;
    case (state_q)
      ACCU_IDLE: begin
        if (load) begin
          pat_d = pattern;
          len_d = len_clamped;
        end
        if (start) begin
          idx_d       = '0;
          resp_word_d = '0;
          if (len_d != '0) begin
            state_n  = ACCU_SETUP;
            in_bit_d = pat_d[0];
          end else begin
            state_n = ACCU_DONE;
          end
        end
      end
      ACCU_SETUP: begin
        if (tmr_zero) state_n = ACCU_STROBE;
      end
      ACCU_STROBE: begin
        if (tmr_zero) state_n = ACCU_SAMPLE;
      end
      ACCU_SAMPLE: begin
        resp_word_d[idx_q] = resp;
        if (last_bit) begin
          state_n = ACCU_DONE;
        end else begin
          idx_d    = idx_q + IDX_W'(1);
          in_bit_d = pat_q[idx_d];
          state_n  = ACCU_SETUP;
        end
      end
      ACCU_DONE: begin
        state_n = ACCU_IDLE;
      end
      default: begin
        state_n = ACCU_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCU_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Datapath and registered outputs, all decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      in_bit        <= 1'b0;
      next          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      resp_word     <= '0;
      state_display <= ACCU_IDLE;
    end else begin
      pat_q         <= pat_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      in_bit        <= in_bit_d;
      next          <= (state_n == ACCU_STROBE);
      busy          <= (state_n == ACCU_SETUP) || (state_n == ACCU_STROBE) ||
                       (state_n == ACCU_SAMPLE);
      done          <= (state_n == ACCU_DONE);
      resp_word     <= resp_word_d;
      state_display <= state_n;
    end
  end

`ifdef ACCU_TX_CHECK_EN
  logic [PATTERN_W-1:0] exp_q, exp_d;
  logic [PATTERN_W-1:0] len_mask;

  // Compare word follows the same load rule as the pattern.
  always_comb begin
    exp_d = exp_q;
    if ((state_q == ACCU_IDLE) && load) exp_d = expected;
  end

  // Only bits below the run length take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PATTERN_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len_d);
    end
  end

  // Flag evaluated on the final resp_word as DONE is entered, cleared on start.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q    <= '0;
      mismatch <= 1'b0;
    end else begin
      exp_q <= exp_d;
      if (state_n == ACCU_DONE) begin
        mismatch <= |((resp_word_d ^ exp_d) & len_mask);
      end else if ((state_q == ACCU_IDLE) && start) begin
        mismatch <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_accu_stim_tx.sv
// Directed self-checking bench for accu_stim_tx (PATTERN_W=16, GAP=2, HOLD=2).
module tb_accu_stim_tx;
  import accu_pkg::*;

  localparam int PW  = 16;
  localparam int G   = 2;
  localparam int H   = 2;
  localparam int LW  = 5;
  localparam int PER = G + H + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] pattern = '0;
  logic [LW-1:0] len = '0;
  logic          resp_inv = 1'b0;
  logic          resp;
  logic          in_bit, next, busy, done;
  logic [PW-1:0] resp_word;
  logic [2:0]    state_display;
`ifdef ACCU_TX_CHECK_EN
  logic [PW-1:0] exp_v = '0;
  logic          mismatch;
`endif

  int checks = 0;
  int errors = 0;

  // Loopback (or inverted loopback) of in_bit into resp.
  assign resp = in_bit ^ resp_inv;

  always #5 clk = ~clk;

  accu_stim_tx #(
    .PATTERN_W   (PW),
    .GAP_CYCLES  (G),
    .HOLD_CYCLES (H)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .pattern       (pattern),
    .len           (len),
    .start         (start),
    .resp          (resp),
`ifdef ACCU_TX_CHECK_EN
    .expected      (exp_v),
    .mismatch      (mismatch),
`endif
    .in_bit        (in_bit),
    .next          (next),
    .busy          (busy),
    .done          (done),
    .resp_word     (resp_word),
    .state_display (state_display)
  );

  // Cumulative strobe monitor: next rising edges, in_bit per strobe,
  // in_bit changes while next is high, busy cycles.
  int            edges = 0;
  int            stab_cnt = 0;
  int            busy_cnt = 0;
  logic [PW-1:0] seq_sr = '0;
  logic          next_prev = 1'b0;
  logic          in_prev = 1'b0;

  always @(negedge clk) begin
    if (next && !next_prev) begin
      edges  <= edges + 1;
      seq_sr <= {in_bit, seq_sr[PW-1:1]};
    end
    if (next && (in_bit !== in_prev)) stab_cnt <= stab_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    next_prev <= next;
    in_prev   <= in_bit;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // One run: optional load with start in the same cycle, bounded wait for done.
  task automatic send(input logic [PW-1:0] p, input logic [LW-1:0] l, input logic do_load,
                      output int lat, output int n_edges, output logic [PW-1:0] bits,
                      output int n_busy, output int n_stab);
    int e0, b0, s0;
    @(negedge clk);
    pattern = p;
    len     = l;
    load    = do_load;
    start   = 1'b1;
    #1;
    e0 = edges;
    b0 = busy_cnt;
    s0 = stab_cnt;
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("state_in_done", state_display, 32'(ACCU_DONE));
    @(posedge clk);
    #1;
    check_val("done_one_cycle", done, 0);
    check_val("idle_after_done", state_display, 32'(ACCU_IDLE));
    n_edges = edges - e0;
    n_busy  = busy_cnt - b0;
    n_stab  = stab_cnt - s0;
    if (n_edges <= 0)       bits = '0;
    else if (n_edges >= PW) bits = seq_sr;
    else                    bits = seq_sr >> (PW - n_edges);
  endtask

  int            lat, ne, nb, ns, e0, k;
  logic [PW-1:0] bits;

  initial begin
    // Reset held 10 cycles with load/start asserted: must be ignored.
    pattern = 16'hFFFF;
    len     = 5'd4;
    load    = 1'b1;
    start   = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_val("rst_next", next, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_in_bit", in_bit, 0);
    check_val("rst_resp_word", resp_word, 0);
    check_val("rst_state", state_display, 0);
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check_val("post_rst_state", state_display, 0);
    check_val("post_rst_busy", busy, 0);

    // Start with no load: latched len is still 0 from reset.
    send(16'hFFFF, 5'd4, 1'b0, lat, ne, bits, nb, ns);
    check_val("noload_latency", lat, 1);
    check_val("noload_strobes", ne, 0);
    check_val("noload_busy", nb, 0);

    // Main loopback run.
    send(16'h0FA9, 5'd12, 1'b1, lat, ne, bits, nb, ns);
    check_val("lb_latency", lat, 12 * PER + 1);
    check_val("lb_strobes", ne, 12);
    check_val("lb_in_bit_seq", bits, 16'h0FA9);
    check_val("lb_resp_word", resp_word, 16'h0FA9);
    check_val("lb_busy_cycles", nb, 12 * PER);
    check_val("lb_in_bit_stable", ns, 0);
    check_val("lb_in_bit_hold", in_bit, 1);
`ifdef ACCU_TX_CHECK_EN
    check_val("chk_match", mismatch, 0);
`endif

    // len = 0.
    send(16'h1234, 5'd0, 1'b1, lat, ne, bits, nb, ns);
    check_val("len0_latency", lat, 1);
    check_val("len0_strobes", ne, 0);
    check_val("len0_busy", nb, 0);

    // len = 20 clamped, inverted response, load/start poked mid-run.
    resp_inv = 1'b1;
    e0 = edges;
    fork
      send(16'hA5C3, 5'd20, 1'b1, lat, ne, bits, nb, ns);
      begin
        for (k = 0; k < 400; k++) begin
          @(negedge clk);
          #1;
          if (edges - e0 >= 3) break;
        end
        pattern = 16'hFFFF;
        len     = 5'd3;
        load    = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        start   = 1'b0;
      end
    join
    check_val("clamp_latency", lat, 16 * PER + 1);
    check_val("clamp_strobes", ne, 16);
    check_val("clamp_in_bit_seq", bits, 16'hA5C3);
    check_val("clamp_resp_word", resp_word, 16'h5A3C);
    check_val("clamp_in_bit_stable", ns, 0);
    resp_inv = 1'b0;

    // Load in one cycle, change inputs, then start without load.
    @(negedge clk);
    pattern = 16'h0005;
    len     = 5'd3;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    send(16'hFFFF, 5'd16, 1'b0, lat, ne, bits, nb, ns);
    check_val("latch_latency", lat, 3 * PER + 1);
    check_val("latch_strobes", ne, 3);
    check_val("latch_in_bit_seq", bits, 16'h0005);
    check_val("latch_resp_word", resp_word, 16'h0005);

`ifdef ACCU_TX_CHECK_EN
    exp_v = 16'h0FA8;
    send(16'h0FA9, 5'd12, 1'b1, lat, ne, bits, nb, ns);
    check_val("chk_mismatch", mismatch, 1);
    exp_v = 16'hFFA9;
    send(16'h0FA9, 5'd12, 1'b1, lat, ne, bits, nb, ns);
    check_val("chk_masked", mismatch, 0);
`endif

    // Reset during the STROBE of bit 5.
    @(negedge clk);
    pattern = 16'hFFFF;
    len     = 5'd16;
    load    = 1'b1;
    start   = 1'b1;
    #1;
    e0 = edges;
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if ((edges - e0 == 6) && next) break;
    end
    check_val("abort_reached_bit5", edges - e0, 6);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("abort_next", next, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_state", state_display, 0);
    check_val("abort_resp_word", resp_word, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_stays_idle", state_display, 0);
    check_val("abort_no_strobe", edges - e0, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
